// File: rtl/scan_matriz.sv
// scan_matriz: row-scan sequencer and double-buffered 7x5 frame store for the
// 5x7 LED matrix plus digit slot output stage.
//
// Slot 0 selects the digit slot (col forced to zero). Slots 1..7 select matrix
// rows L1..L7 and drive the displayed (front) buffer row. Writes go to a back
// buffer. A commit locks the back buffer and swaps it into the front buffer at
// the next frame wrap, so a refresh never shows a half-written image.
//
// Build option: define SCAN_BLANK_EN to blank col for the first BLANK cycles
// of every slot (sel already shows the new slot while col is blanked).

module scan_matriz #(
    parameter int DWELL = 1000,   // cycles per slot, >= 2
    parameter int CNT_W = 10,     // dwell counter width, 2^CNT_W >= DWELL
    parameter int BLANK = 4       // blanking cycles per slot, < DWELL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_wr_en,
    input  logic [2:0] i_wr_row,
    input  logic [4:0] i_wr_data,
    output logic       o_wr_ready,
    input  logic       i_commit,
    output logic [2:0] o_sel,
    output logic [4:0] o_col,
    output logic       o_frame_done
);

    // Two-state buffer handshake: IDLE accepts writes, PENDING waits for wrap.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

`ifdef SCAN_BLANK_EN
    localparam logic BLANK_ON = 1'b1;
`else
    localparam logic BLANK_ON = 1'b0;
`endif

    // Row r (1..7) of a frame lives at bits [5*(r-1) +: 5].
    function automatic logic [4:0] row_pattern(input logic [34:0] frame_v,
                                               input logic [2:0]  row);
        logic [4:0] pat;
        case (row)
            3'd1:    pat = frame_v[4:0];
            3'd2:    pat = frame_v[9:5];
            3'd3:    pat = frame_v[14:10];
            3'd4:    pat = frame_v[19:15];
            3'd5:    pat = frame_v[24:20];
            3'd6:    pat = frame_v[29:25];
            3'd7:    pat = frame_v[34:30];
            default: pat = 5'b00000;   // digit slot shows no columns
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_slot;
    state_t           r_state;
    logic [34:0]      r_front;
    logic [34:0]      r_back;
    logic [2:0]       r_sel;
    logic [4:0]       r_col;
    logic             r_wr_ready;
    logic             r_frame_done;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_slot_nxt;
    logic             w_terminal;
    logic             w_wrap;
    state_t           w_state_nxt;
    logic             w_swap;
    logic             w_wr_accept;
    logic             w_blank;

    // Dwell/slot sequencing: terminal cycle advances slot, slot 7 terminal is the frame wrap.
    always_comb begin
        w_terminal = (r_cnt == CNT_LAST);
        w_wrap     = w_terminal && (r_slot == 3'd7);
        if (w_terminal) begin
            w_cnt_nxt  = CNT_ZERO;
            w_slot_nxt = r_slot + 3'd1;
        end else begin
            w_cnt_nxt  = r_cnt + CNT_ONE;
            w_slot_nxt = r_slot;
        end
    end

    // Dwell and slot counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= CNT_ZERO;
            r_slot <= 3'd0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_slot <= w_slot_nxt;
        end
    end

    // Handshake next state: commit locks writes; the wrap performs the swap.
    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        w_wr_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A write in the commit cycle still lands and joins the swap.
                w_wr_accept = i_wr_en && (i_wr_row != 3'd0);
                if (i_commit) begin
                    w_state_nxt = ST_PENDING;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PENDING: begin
                // Writes and repeated commits are ignored while locked.
                if (w_wrap) begin
                    w_swap      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_PENDING;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake state register; reset drops any pending swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Back buffer: accepted writes land on the accepting edge; contents survive a swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_back <= 35'd0;
        end else begin
            for (int r = 1; r <= 7; r++) begin
                if (w_wr_accept && (i_wr_row == 3'(r))) begin
                    r_back[5*(r-1) +: 5] <= i_wr_data;
                end
            end
        end
    end

    // Front buffer: replaced by the back buffer only at a frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_front <= 35'd0;
        end else if (w_swap) begin
            r_front <= r_back;
        end else begin
            r_front <= r_front;
        end
    end

    // Blank window covers the first BLANK cycles of the slot being entered.
    always_comb begin
        w_blank = BLANK_ON && (w_cnt_nxt < CNT_BLANK);
    end

    // Registered outputs: sel/col track the upcoming slot so they change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel        <= 3'd0;
            r_col        <= 5'b00000;
            r_wr_ready   <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_sel <= w_slot_nxt;
            // At a wrap the next slot is 0, so the swapped front is never needed here.
            if (w_blank || (w_slot_nxt == 3'd0)) begin
                r_col <= 5'b00000;
            end else begin
                r_col <= row_pattern(r_front, w_slot_nxt);
            end
            r_wr_ready   <= (w_state_nxt == ST_IDLE);
            r_frame_done <= w_swap;
        end
    end

    assign o_sel        = r_sel;
    assign o_col        = r_col;
    assign o_wr_ready   = r_wr_ready;
    assign o_frame_done = r_frame_done;

endmodule
